// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer. Latency is 1 cycle and throughput is 1 word/cycle.
// InReady depends only on registered state and En. Flush, freeze and a stall-cycle counter are included.
module pipe_stage_skid #(
   parameter int                 DATA_W    = 64,
   parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
   parameter int                 CNT_W     = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              En,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic [DATA_W-1:0] InData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] OutData,
   output logic [1:0]        Count,
   output logic [CNT_W-1:0]  StallCycles,
   input  logic              ClrCnt
);

   logic              m_vld, s_vld;
   logic [DATA_W-1:0] m_dat, s_dat;
   logic              accept, pop;

   assign InReady  = En & ~s_vld;
   assign OutValid = En & m_vld;
   assign OutData  = OutValid ? m_dat : NOP_VALUE;
   assign accept   = InValid & InReady;
   assign pop      = OutValid & OutReady;
   assign Count    = 2'(m_vld) + 2'(s_vld);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         m_vld <= 1'b0;
         s_vld <= 1'b0;
         m_dat <= NOP_VALUE;
         s_dat <= NOP_VALUE;
      end else if (Flush) begin
         // A word popped this cycle is already owned by the consumer.
         m_vld <= 1'b0;
         s_vld <= 1'b0;
         m_dat <= NOP_VALUE;
         s_dat <= NOP_VALUE;
      end else if (En) begin
         if (accept && !pop) begin
            if (!m_vld) begin
               m_vld <= 1'b1;
               m_dat <= InData;
            end else begin
               s_vld <= 1'b1;
               s_dat <= InData;
            end
         end else if (pop && !accept) begin
            if (s_vld) begin
               m_dat <= s_dat;
               s_vld <= 1'b0;
               s_dat <= NOP_VALUE;
            end else begin
               m_vld <= 1'b0;
               m_dat <= NOP_VALUE;
            end
         end else if (accept && pop) begin
            if (s_vld) begin
               m_dat <= s_dat;
               s_dat <= InData;
            end else begin
               m_dat <= InData;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         StallCycles <= '0;
      end else if (ClrCnt) begin
         StallCycles <= '0;
      end else if (OutValid && !OutReady && (StallCycles != {CNT_W{1'b1}})) begin
         StallCycles <= StallCycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with hand-computed expected values (CNT_W=4).
module tb_pipe_stage_skid;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b1;
   logic        En = 1'b0, Flush = 1'b0, InValid = 1'b0, OutReady = 1'b0, ClrCnt = 1'b0;
   logic [63:0] InData = '0;
   logic        InReady, OutValid;
   logic [63:0] OutData;
   logic [1:0]  Count;
   logic [3:0]  StallCycles;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [63:0] W0 = 64'h00400000_20080005;
   localparam logic [63:0] W1 = 64'h00400004_200A0003;
   localparam logic [63:0] G  = 64'hDEADBEEF_00000001;

   pipe_stage_skid #(.DATA_W(64), .NOP_VALUE(64'h0), .CNT_W(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .Flush(Flush),
      .InValid(InValid), .InReady(InReady), .InData(InData),
      .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
      .Count(Count), .StallCycles(StallCycles), .ClrCnt(ClrCnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // reset state
      #1 Rst_n = 1'b0;
      #1;
      chk("rst_ovld", 64'(OutValid), 64'd0);
      chk("rst_odat", OutData, 64'd0);
      chk("rst_cnt", 64'(Count), 64'd0);
      chk("rst_stall", 64'(StallCycles), 64'd0);
      Rst_n = 1'b1;
      En = 1'b1; OutReady = 1'b1; InValid = 1'b1; InData = W0;
      #1;
      chk("rst_irdy", 64'(InReady), 64'd1);

      // streaming
      tick();
      InData = W1;
      #1;
      chk("str_ovld0", 64'(OutValid), 64'd1);
      chk("str_odat0", OutData, W0);
      chk("str_cnt0", 64'(Count), 64'd1);
      chk("str_irdy0", 64'(InReady), 64'd1);
      tick();
      InValid = 1'b0;
      #1;
      chk("str_odat1", OutData, W1);
      chk("str_cnt1", 64'(Count), 64'd1);
      tick();
      chk("str_ovld2", 64'(OutValid), 64'd0);
      chk("str_odat2", OutData, 64'd0);
      chk("str_stall", 64'(StallCycles), 64'd0);

      // backpressure into the skid entry
      OutReady = 1'b0; InValid = 1'b1; InData = 64'h1;
      tick();
      InData = 64'h2;
      tick();
      InData = 64'h3;
      #1;
      chk("bp_cnt", 64'(Count), 64'd2);
      chk("bp_irdy", 64'(InReady), 64'd0);
      chk("bp_odat", OutData, 64'h1);
      chk("bp_stall1", 64'(StallCycles), 64'd1);
      tick();
      chk("bp_stall2", 64'(StallCycles), 64'd2);
      chk("bp_cnt2", 64'(Count), 64'd2);
      OutReady = 1'b1;
      tick();
      chk("bp_odatB", OutData, 64'h2);
      chk("bp_irdy1", 64'(InReady), 64'd1);
      chk("bp_cntB", 64'(Count), 64'd1);
      tick();
      InValid = 1'b0;
      #1;
      chk("bp_odatC", OutData, 64'h3);
      tick();
      chk("bp_cnt_end", 64'(Count), 64'd0);
      chk("bp_stall_end", 64'(StallCycles), 64'd2);
      ClrCnt = 1'b1;
      tick();
      ClrCnt = 1'b0;
      chk("clr0", 64'(StallCycles), 64'd0);

      // flush with the stage full and a word offered
      OutReady = 1'b0; InValid = 1'b1; InData = 64'h11;
      tick();
      InData = 64'h22;
      tick();
      InData = 64'h33; Flush = 1'b1; OutReady = 1'b1;
      #1;
      chk("fl_cnt_pre", 64'(Count), 64'd2);
      chk("fl_stall_pre", 64'(StallCycles), 64'd1);
      tick();
      Flush = 1'b0; InValid = 1'b0;
      #1;
      chk("fl_ovld", 64'(OutValid), 64'd0);
      chk("fl_odat", OutData, 64'd0);
      chk("fl_cnt", 64'(Count), 64'd0);
      chk("fl_stall", 64'(StallCycles), 64'd1);
      tick();
      tick();
      chk("fl_absent", 64'(OutValid), 64'd0);
      ClrCnt = 1'b1;
      tick();
      ClrCnt = 1'b0;

      // freeze
      OutReady = 1'b0; InValid = 1'b1; InData = G;
      tick();
      En = 1'b0; InValid = 1'b1; InData = 64'h55; OutReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("frz_ovld", 64'(OutValid), 64'd0);
         chk("frz_irdy", 64'(InReady), 64'd0);
         chk("frz_odat", OutData, 64'd0);
         tick();
         InValid = ~InValid;
         OutReady = ~OutReady;
      end
      En = 1'b1; InValid = 1'b0; OutReady = 1'b0;
      #1;
      chk("frz_ovld_en", 64'(OutValid), 64'd1);
      chk("frz_odat_en", OutData, G);
      chk("frz_cnt", 64'(Count), 64'd1);
      chk("frz_stall", 64'(StallCycles), 64'd0);

      // saturation and clear
      for (int i = 0; i < 20; i++) tick();
      chk("sat", 64'(StallCycles), 64'd15);
      ClrCnt = 1'b1;
      tick();
      ClrCnt = 1'b0;
      chk("sat_clr", 64'(StallCycles), 64'd0);
      tick();
      chk("sat_recount", 64'(StallCycles), 64'd1);

      // async reset mid-stream
      InValid = 1'b1; InData = 64'h77;
      tick();
      InValid = 1'b0;
      chk("ar_cnt_pre", 64'(Count), 64'd2);
      #2 Rst_n = 1'b0;
      #1;
      chk("ar_ovld", 64'(OutValid), 64'd0);
      chk("ar_odat", OutData, 64'd0);
      chk("ar_cnt", 64'(Count), 64'd0);
      Rst_n = 1'b1;
      InValid = 1'b1; InData = 64'hABCD; OutReady = 1'b1;
      #1;
      chk("ar_irdy", 64'(InReady), 64'd1);
      tick();
      InValid = 1'b0;
      #1;
      chk("ar_ovld1", 64'(OutValid), 64'd1);
      chk("ar_odat1", OutData, 64'hABCD);
      tick();
      chk("ar_cnt_end", 64'(Count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
